mon_exp_param: RTL and testbench
================================

// Module: mon_exp_param
// PURPOSE
// Parametrised Montgomery modular exponentiator: ans = M^e mod n for Montgomery-domain operands.
// Successor to fixed-width mon_exp: generic operand/exponent widths, internal bit-serial radix-2 MonPro,
// busy/stop handshake, even-modulus error flag, optional Montgomery-domain output. Sits under RSA top level.
// PARAMETERS
// BIT_LEN  64  operand/modulus width; R = 2^BIT_LEN
// EXP_LEN  64  exponent width; all EXP_LEN bits scanned MSB->LSB
// PORTS
// clk       in   1        rising-edge clock
// rst       in   1        synchronous, active-high reset
// start     in   1        request; sampled only in IDLE
// out_mont  in   1        1: return result in Montgomery domain (skip final conversion)
// M_bar     in   BIT_LEN  M*R mod n, must be < n
// x_bar     in   BIT_LEN  R mod n (Montgomery one), must be < n
// e         in   EXP_LEN  exponent
// n         in   BIT_LEN  modulus, must be odd
// busy      out  1        high from cycle after start accept until stop cycle inclusive
// stop      out  1        one-cycle completion pulse
// ans       out  BIT_LEN  result, valid from stop, held until next accepted start
// err       out  1        set with stop when n even; held with ans
// BEHAVIOUR
// - Reset (any state, mid-op included): state=IDLE; busy=0, stop=0, ans=0, err=0; operation discarded.
// - IDLE: start=1 latches M_bar, x_bar, e, n, out_mont into internal regs; clears err; ans held until stop.
//   start while busy ignored; inputs need only be valid in the accept cycle.
// - Even n (n[0]=0) at accept: no MonPro run; next cycle stop=1, err=1, ans=0, back to IDLE.
// - States: IDLE -> SQR -> (MUL if e bit=1) -> next bit SQR ... -> CONV (unless out_mont) -> DONE -> IDLE.
//   acc initialised to x_bar; SQR: acc=MonPro(acc,acc); MUL: acc=MonPro(M_bar,acc); CONV: acc=MonPro(acc,1).
// - MonPro(a,b), exactly BIT_LEN+1 cycles: u=0 (width BIT_LEN+2); for i=0..BIT_LEN-1 one cycle each:
//   u=u+a[i]*b; if u odd u=u+n; u=u>>1. Final cycle: if u>=n u=u-n. Invariant u<2n; result < n.
// - Latency start-accept edge to stop: 1 + N*(BIT_LEN+1) cycles, N = EXP_LEN + popcount(e) + (out_mont?0:1).
// - DONE: one cycle, stop=1, ans=acc[BIT_LEN-1:0], busy=1; next cycle busy=0, IDLE; start accepted there.
// - e=0: result = conversion of x_bar = 1 (or x_bar when out_mont=1).
// - n=1 (odd): all results 0, no special case.
// - Operands >= n: result undefined, no error flagged.
// TESTING
// BIT_LEN=8, EXP_LEN=8, n=143 (R=256, x_bar=113), M=5 -> M_bar=136, unless noted.
// 1. e=7, out_mont=0, start 1 cycle -> stop after 1+(8+3+1)*9=109 cycles, ans=47, err=0.
// 2. e=7, out_mont=1 -> stop after 100 cycles, ans=20 (47*256 mod 143).
// 3. e=0, out_mont=0 -> ans=1 after 1+9*9=82 cycles; e=1 -> ans=5 after 91 cycles.
// 4. n=142 -> stop 1 cycle after accept, err=1, ans=0; following run with n=143,e=7 -> err=0, ans=47.
// 5. start re-pulsed mid-run with e=1 -> ignored, run 1 still ends ans=47; rst mid-run -> busy/stop/ans=0 next cycle.
// 6. Back-to-back: start held high -> new accept cycle right after busy drops; ans held 47 until 2nd stop.

Source files
------------

// File: rtl/mon_exp_param.sv
// Parametrised Montgomery modular exponentiator: ans = M^e mod n with Montgomery-domain operands.
// Left-to-right square-and-multiply over all EXP_LEN exponent bits, each step a bit-serial radix-2
// Montgomery product taking BIT_LEN+1 cycles. An even modulus is rejected with err instead of a run.
module mon_exp_param #(
    parameter int BIT_LEN = 64,
    parameter int EXP_LEN = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               out_mont,
    input  logic [BIT_LEN-1:0] M_bar,
    input  logic [BIT_LEN-1:0] x_bar,
    input  logic [EXP_LEN-1:0] e,
    input  logic [BIT_LEN-1:0] n,
    output logic               busy,
    output logic               stop,
    output logic [BIT_LEN-1:0] ans,
    output logic               err
);

    localparam int CW = $clog2(BIT_LEN + 1);
    localparam int BW = $clog2(EXP_LEN + 1);

    typedef enum logic [2:0] {IDLE, SETUP, SQR, MUL, CONV, DONE} state_t;

    state_t             state_q, state_d;
    logic [BIT_LEN-1:0] m_bar_q, m_bar_d;
    logic [BIT_LEN-1:0] n_q, n_d;
    logic [EXP_LEN-1:0] e_sh_q, e_sh_d;
    logic               out_mont_q, out_mont_d;
    logic [BIT_LEN-1:0] a_sh_q, a_sh_d;
    logic [BIT_LEN-1:0] b_q, b_d;
    logic [BIT_LEN+1:0] u_q, u_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [BW-1:0]      bits_left_q, bits_left_d;
    logic [BIT_LEN-1:0] ans_q, ans_d;
    logic               err_q, err_d;

    logic               mp_last;
    logic [BIT_LEN+1:0] u_add, u_odd, u_step;
    logic [BIT_LEN-1:0] mp_res;
    logic               mp_go;
    logic [BIT_LEN-1:0] mp_a, mp_b;

    // One MonPro iteration: add a[i]*b, make even by adding n, halve; plus the final conditional subtract.
    always_comb begin
        mp_last = (cnt_q == CW'(BIT_LEN));
        u_add   = u_q + {2'b00, b_q & {BIT_LEN{a_sh_q[0]}}};
        u_odd   = u_add + (u_add[0] ? {2'b00, n_q} : '0);
        u_step  = u_odd >> 1;
        mp_res  = (u_q >= {2'b00, n_q}) ? BIT_LEN'(u_q - {2'b00, n_q}) : u_q[BIT_LEN-1:0];
    end

    // Sequencer: picks the next product (square, multiply, conversion) and loads its operands.
    always_comb begin
        state_d     = state_q;
        m_bar_d     = m_bar_q;
        n_d         = n_q;
        e_sh_d      = e_sh_q;
        out_mont_d  = out_mont_q;
        a_sh_d      = a_sh_q;
        b_d         = b_q;
        u_d         = u_q;
        cnt_d       = cnt_q;
        bits_left_d = bits_left_q;
        ans_d       = ans_q;
        err_d       = err_q;
        mp_go       = 1'b0;
        mp_a        = '0;
        mp_b        = '0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = SETUP;
                    m_bar_d     = M_bar;
                    n_d         = n;
                    e_sh_d      = e;
                    out_mont_d  = out_mont;
                    bits_left_d = BW'(EXP_LEN);
                    err_d       = 1'b0;
                    mp_go       = 1'b1;
                    mp_a        = x_bar;
                    mp_b        = x_bar;
                end
            end
            SETUP: begin
                if (!n_q[0]) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                    ans_d   = '0;
                end else begin
                    state_d = SQR;
                end
            end
            SQR, MUL, CONV: begin
                if (!mp_last) begin
                    u_d    = u_step;
                    a_sh_d = a_sh_q >> 1;
                    cnt_d  = cnt_q + CW'(1);
                end else if (state_q == SQR && e_sh_q[EXP_LEN-1]) begin
                    state_d = MUL;
                    mp_go   = 1'b1;
                    mp_a    = m_bar_q;
                    mp_b    = mp_res;
                end else if (state_q == CONV) begin
                    state_d = DONE;
                    ans_d   = mp_res;
                end else if (bits_left_q > BW'(1)) begin
                    state_d     = SQR;
                    bits_left_d = bits_left_q - BW'(1);
                    e_sh_d      = e_sh_q << 1;
                    mp_go       = 1'b1;
                    mp_a        = mp_res;
                    mp_b        = mp_res;
                end else if (out_mont_q) begin
                    state_d = DONE;
                    ans_d   = mp_res;
                end else begin
                    state_d = CONV;
                    mp_go   = 1'b1;
                    mp_a    = mp_res;
                    mp_b    = BIT_LEN'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (mp_go) begin
            a_sh_d = mp_a;
            b_d    = mp_b;
            u_d    = '0;
            cnt_d  = '0;
        end
    end

    // State and datapath registers; reset abandons any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            m_bar_q     <= '0;
            n_q         <= '0;
            e_sh_q      <= '0;
            out_mont_q  <= 1'b0;
            a_sh_q      <= '0;
            b_q         <= '0;
            u_q         <= '0;
            cnt_q       <= '0;
            bits_left_q <= '0;
            ans_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            m_bar_q     <= m_bar_d;
            n_q         <= n_d;
            e_sh_q      <= e_sh_d;
            out_mont_q  <= out_mont_d;
            a_sh_q      <= a_sh_d;
            b_q         <= b_d;
            u_q         <= u_d;
            cnt_q       <= cnt_d;
            bits_left_q <= bits_left_d;
            ans_q       <= ans_d;
            err_q       <= err_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign stop = (state_q == DONE);
    assign ans  = ans_q;
    assign err  = err_q;

endmodule

// File: tb/tb_mon_exp_param.sv
// Directed bench for mon_exp_param at BIT_LEN=EXP_LEN=8; expected results come from a plain
// integer modular-exponent model and are queued at start, then popped when stop appears.
module tb_mon_exp_param;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       out_mont;
    logic [7:0] M_bar;
    logic [7:0] x_bar;
    logic [7:0] e;
    logic [7:0] n;
    logic       busy;
    logic       stop;
    logic [7:0] ans;
    logic       err;

    int     checks = 0;
    int     errors = 0;
    longint acceptTime;

    typedef struct {
        string      tag;
        logic [7:0] ans;
        logic       err;
        int         lat;
    } exp_t;

    exp_t sb[$];

    mon_exp_param #(.BIT_LEN(8), .EXP_LEN(8)) dut (
        .clk(clk), .rst(rst), .start(start), .out_mont(out_mont),
        .M_bar(M_bar), .x_bar(x_bar), .e(e), .n(n),
        .busy(busy), .stop(stop), .ans(ans), .err(err)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Reference model: plain-domain modular exponent plus the cycle count of the run.
    function automatic void pushExpected(input string tag, input int m, input int ex, input int nn, input bit mont);
        exp_t   x;
        longint r;
        int     pc;
        x.tag = tag;
        if (nn % 2 == 0) begin
            x.ans = 8'd0;
            x.err = 1'b1;
            x.lat = 1;
        end else begin
            r = 1 % nn;
            for (int i = 0; i < ex; i++) r = (r * m) % nn;
            if (mont) r = (r * 256) % nn;
            pc = 0;
            for (int i = 0; i < 8; i++) if (((ex >> i) & 1) == 1) pc++;
            x.ans = 8'(r);
            x.err = 1'b0;
            x.lat = 1 + (8 + pc + (mont ? 0 : 1)) * 9;
        end
        sb.push_back(x);
    endfunction

    task automatic setInputs(input int m, input int ex, input int nn, input bit mont);
        M_bar    = 8'((m * 256) % nn);
        x_bar    = 8'(256 % nn);
        e        = 8'(ex);
        n        = 8'(nn);
        out_mont = mont;
    endtask

    task automatic applyStimulus(input string tag, input int m, input int ex, input int nn, input bit mont, input bit hold);
        @(negedge clk);
        setInputs(m, ex, nn, mont);
        start = 1'b1;
        pushExpected(tag, m, ex, nn, mont);
        @(posedge clk);
        acceptTime = $time;
        #1;
        if (!hold) start = 1'b0;
        @(negedge clk);
        check({tag, "_busy"}, 32'(busy), 32'd1);
    endtask

    task automatic checkOutput();
        exp_t x;
        int   budget;
        int   lat;
        budget = 0;
        while (!stop && budget < 3000) begin
            @(negedge clk);
            budget++;
        end
        x = sb.pop_front();
        if (!stop) begin
            checks++;
            errors++;
            $error("[TB] FAIL %s_timeout observed=no_stop expected=stop", x.tag);
        end else begin
            lat = int'(($time - acceptTime - 5) / 10);
            check({x.tag, "_lat"}, 32'(lat), 32'(x.lat));
            check({x.tag, "_ans"}, 32'(ans), 32'(x.ans));
            check({x.tag, "_err"}, 32'(err), 32'(x.err));
            check({x.tag, "_busy_at_stop"}, 32'(busy), 32'd1);
        end
    endtask

    initial begin
        exp_t dropped;
        rst   = 1'b1;
        start = 1'b0;
        setInputs(0, 0, 143, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_stop", 32'(stop), 32'd0);
        check("reset_ans", 32'(ans), 32'd0);
        check("reset_err", 32'(err), 32'd0);

        applyStimulus("e7", 5, 7, 143, 1'b0, 1'b0);
        checkOutput();
        @(negedge clk);
        check("e7_busy_after", 32'(busy), 32'd0);
        check("e7_ans_held", 32'(ans), 32'd47);

        applyStimulus("e7_mont", 5, 7, 143, 1'b1, 1'b0);
        checkOutput();
        applyStimulus("e0", 5, 0, 143, 1'b0, 1'b0);
        checkOutput();
        applyStimulus("e1", 5, 1, 143, 1'b0, 1'b0);
        checkOutput();
        applyStimulus("e0_mont", 5, 0, 143, 1'b1, 1'b0);
        checkOutput();

        applyStimulus("even_n", 5, 7, 142, 1'b0, 1'b0);
        checkOutput();
        applyStimulus("after_even", 5, 7, 143, 1'b0, 1'b0);
        checkOutput();

        applyStimulus("m2_e255", 2, 255, 143, 1'b0, 1'b0);
        checkOutput();
        applyStimulus("m142_e128_mont", 142, 128, 143, 1'b1, 1'b0);
        checkOutput();
        applyStimulus("n1", 0, 5, 1, 1'b0, 1'b0);
        checkOutput();

        applyStimulus("repulse", 5, 7, 143, 1'b0, 1'b0);
        repeat (20) @(negedge clk);
        setInputs(5, 1, 143, 1'b0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        setInputs(0, 0, 143, 1'b0);
        checkOutput();

        applyStimulus("midrst", 5, 7, 143, 1'b0, 1'b0);
        dropped = sb.pop_front();
        repeat (30) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_stop", 32'(stop), 32'd0);
        check("midrst_ans", 32'(ans), 32'd0);
        check("midrst_err", 32'(err), 32'd0);

        applyStimulus("b2b_first", 5, 7, 143, 1'b0, 1'b1);
        checkOutput();
        setInputs(5, 3, 143, 1'b0);
        pushExpected("b2b_second", 5, 3, 143, 1'b0);
        @(negedge clk);
        check("b2b_gap_busy", 32'(busy), 32'd0);
        check("b2b_gap_ans", 32'(ans), 32'd47);
        @(posedge clk);
        acceptTime = $time;
        #1;
        start = 1'b0;
        repeat (20) @(negedge clk);
        check("b2b_run_busy", 32'(busy), 32'd1);
        check("b2b_run_ans_held", 32'(ans), 32'd47);
        checkOutput();

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
